adder_accumulate_sequencer: RTL

- Sequential front/back end for the 16-bit combinational carry-select adder.
- Holds the A operand (accumulator) and B operand (loaded from switches) in registers and drives them into the adder.
- On each Run press, waits a fixed settle time, then captures the adder's Sum/carry back into the accumulator.
- Sits between the board switches/buttons and the adder; its outputs also feed the hex displays and LEDs.

---
 rtl/adder_accumulate_sequencer.sv | 124 ++++++++++++
 1 files changed

// File: rtl/adder_accumulate_sequencer.sv
// adder_accumulate_sequencer
//
// Sequential front/back end for an external combinational adder. It holds
// the accumulator (A) and the switch-loaded operand (B) in registers. Both
// registers drive the adder. On each rising edge of Run, the block waits
// SETTLE_CYCLES cycles for the adder output to settle. It then captures the
// sum, the carry-out and the signed overflow back into the accumulator.
//
// Parameters
//   WIDTH          operand/sum width in bits
//   SETTLE_CYCLES  settle cycles before capture (legal range 1..15)
//
// Ports
//   Clk     in   system clock, rising-edge active
//   Reset   in   synchronous active-high reset (all registers)
//   LoadB   in   level; loads SW into B while idle
//   Run     in   level, pre-synchronised; a rising edge starts one add
//   SW      in   switch value for B
//   Sum_in  in   sum from the external adder (adder Cin tied 0)
//   CO_in   in   carry-out from the external adder
//   A_out   out  accumulator register
//   B_out   out  B operand register
//   CO      out  carry captured by the last add
//   V       out  signed overflow captured by the last add
//   Busy    out  high whenever the sequencer is not idle
//   Done    out  one-cycle pulse after the accumulator updates
module adder_accumulate_sequencer #(
  parameter int WIDTH         = 16,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             LoadB,
  input  logic             Run,
  input  logic [WIDTH-1:0] SW,
  input  logic [WIDTH-1:0] Sum_in,
  input  logic             CO_in,
  output logic [WIDTH-1:0] A_out,
  output logic [WIDTH-1:0] B_out,
  output logic             CO,
  output logic             V,
  output logic             Busy,
  output logic             Done
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    SETTLE       = 2'd1,
    CAPTURE      = 2'd2,
    WAIT_RELEASE = 2'd3
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] cnt;
  logic [3:0] cnt_nxt;
  logic       run_q;
  logic       run_edge;

  // Two's-complement overflow. It is set when both operands have the same
  // sign and the sum's sign differs from that sign.
  function automatic logic signed_ovf(input logic signed [WIDTH-1:0] a,
                                      input logic signed [WIDTH-1:0] b,
                                      input logic signed [WIDTH-1:0] s);
    return (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
  endfunction

  assign run_edge = Run & ~run_q;

  // Busy is derived from the registered state, so it cannot glitch.
  assign Busy = (state != IDLE);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (run_edge) begin
          state_nxt = SETTLE;
          cnt_nxt   = CNT_INIT;
        end
      end
      SETTLE: begin
        if (cnt != 4'd0) cnt_nxt   = cnt - 4'd1;
        else             state_nxt = CAPTURE;
      end
      CAPTURE: state_nxt = WAIT_RELEASE;
      // Holding Run keeps the sequencer here, so each press yields one add.
      WAIT_RELEASE: begin
        if (!Run) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
      run_q <= 1'b0;
      A_out <= '0;
      B_out <= '0;
      CO    <= 1'b0;
      V     <= 1'b0;
      Done  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      run_q <= Run;
      Done  <= (state == CAPTURE);
      // B is loaded only while idle, so it stays stable during an add. A
      // load coinciding with a Run edge takes effect well before capture.
      if (state == IDLE && LoadB) B_out <= SW;
      if (state == CAPTURE) begin
        A_out <= Sum_in;
        CO    <= CO_in;
        V     <= signed_ovf(A_out, B_out, Sum_in);
      end
    end
  end

endmodule
